// File: rtl/ehgu_gray_seq_rx.sv
// ehgu_gray_seq_rx -- receive end of a gray-coded sequence stream.
//
// Accepts gray words over valid/ready, decodes them to binary, checks each
// accepted word against the previous one (legal step = hamming distance <= 1),
// flags wrap-around from 2**WIDTH-1 to 0 and keeps saturating error / modulo
// wrap statistics. Decoded words leave through a 2-entry output FIFO.
//
// Optional feature macro: EHGU_GRAY_RX_PARITY_EN
//   Adds s_par (even parity over s_gray) and par_err_cnt. Parity-failing
//   words are accepted and dropped without touching ref or step counters.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready input handshake, s_gray input word
//   resync          return to SYNC on the next cycle
//   m_valid/m_ready output handshake
//   m_bin           decoded binary value
//   m_wrap          word wrapped from all-ones to 0
//   m_step_err      word differs from previous in more than one bit
//   state           0=SYNC 1=TRACK 2=LOST
//   err_cnt         step errors, saturating
//   wrap_cnt        wraps seen, modulo 2**WRAP_CNT_W

package ehgu_config_pkg;
  parameter int unsigned DP_WIDTH = 8;
endpackage

module ehgu_gray_seq_rx #(
  parameter int unsigned WIDTH       = ehgu_config_pkg::DP_WIDTH,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned WRAP_CNT_W  = 8,
  parameter int unsigned LOST_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_gray,
`ifdef EHGU_GRAY_RX_PARITY_EN
  input  logic                  s_par,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
`endif
  input  logic                  resync,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_bin,
  output logic                  m_wrap,
  output logic                  m_step_err,
  output logic [1:0]            state,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  localparam int unsigned CW = (LOST_THRESH < 2) ? 1 : $clog2(LOST_THRESH + 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] bin;
    logic             wrap;
    logic             err;
  } entry_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++)
      b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
    return b;
  endfunction

  state_t                st_q, st_d;
  logic [CW-1:0]         consec_q, consec_d;
  logic [WIDTH-1:0]      ref_q, ref_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;
  entry_t                slot0_q, slot1_q, fwd_e;
  logic [1:0]            occ_q;
  logic                  accept, pop, fwd, word_ok;
  logic [WIDTH-1:0]      diff;
  logic                  single, multi;
`ifdef EHGU_GRAY_RX_PARITY_EN
  logic [ERR_CNT_W-1:0]  perr_q, perr_d;
`endif

  always_comb begin
    s_ready = !rst && !resync && (occ_q != 2'd2);
    accept  = s_valid && s_ready;
    pop     = (occ_q != 2'd0) && m_ready;
    diff    = s_gray ^ ref_q;
    // Power-of-two test on the difference: one bit set <=> distance 1.
    multi   = (diff & (diff - WIDTH'(1))) != '0;
    single  = (diff != '0) && !multi;
`ifdef EHGU_GRAY_RX_PARITY_EN
    word_ok = ((^s_gray) == s_par);
    perr_d  = perr_q;
    if (accept && !word_ok && st_q != LOST && perr_q != '1)
      perr_d = perr_q + ERR_CNT_W'(1);
`else
    word_ok = 1'b1;
`endif
    st_d     = st_q;
    consec_d = consec_q;
    ref_d    = ref_q;
    err_d    = err_q;
    wrap_d   = wrap_q;
    fwd      = 1'b0;
    fwd_e    = '0;

    if (resync) begin
      st_d     = SYNC;
      consec_d = '0;
    end else if (accept && word_ok) begin
      case (st_q)
        SYNC: begin
          fwd       = 1'b1;
          fwd_e.bin = gray2bin(s_gray);
          ref_d     = s_gray;
          consec_d  = '0;
          st_d      = TRACK;
        end
        TRACK: begin
          fwd        = 1'b1;
          fwd_e.bin  = gray2bin(s_gray);
          fwd_e.err  = multi;
          fwd_e.wrap = single && (gray2bin(ref_q) == '1) && (s_gray == '0);
          ref_d      = s_gray;
          if (multi) begin
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
            consec_d = consec_q + CW'(1);
            if (consec_d == CW'(LOST_THRESH)) st_d = LOST;
          end else begin
            consec_d = '0;
          end
          if (fwd_e.wrap) wrap_d = wrap_q + WRAP_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= SYNC;
      consec_q <= '0;
      ref_q    <= '0;
      err_q    <= '0;
      wrap_q   <= '0;
`ifdef EHGU_GRAY_RX_PARITY_EN
      perr_q   <= '0;
`endif
    end else begin
      st_q     <= st_d;
      consec_q <= consec_d;
      ref_q    <= ref_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
`ifdef EHGU_GRAY_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  // Slot0 is always the head; a push with a simultaneous pop at occupancy 1
  // lands directly in slot0 (push is impossible at occupancy 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      case ({fwd, pop})
        2'b10: begin
          if (occ_q == 2'd0) slot0_q <= fwd_e;
          else               slot1_q <= fwd_e;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: slot0_q <= fwd_e;
        default: ;
      endcase
    end
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_bin      = slot0_q.bin;
  assign m_wrap     = slot0_q.wrap;
  assign m_step_err = slot0_q.err;
  assign state      = st_q;
  assign err_cnt    = err_q;
  assign wrap_cnt   = wrap_q;
`ifdef EHGU_GRAY_RX_PARITY_EN
  assign par_err_cnt = perr_q;
`endif

endmodule

// File: tb/tb_ehgu_gray_seq_rx.sv
// Bench for ehgu_gray_seq_rx (WIDTH=4, LOST_THRESH=3): directed scenarios
// followed by a randomized phase, all compared against a queue-based model.
module tb_ehgu_gray_seq_rx;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_ready, resync, m_valid, m_ready, m_wrap, m_step_err;
  logic [3:0] s_gray, m_bin;
  logic [1:0] state;
  logic [7:0] err_cnt, wrap_cnt;

  ehgu_gray_seq_rx #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8), .LOST_THRESH(3)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_gray(s_gray),
    .resync(resync), .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin),
    .m_wrap(m_wrap), .m_step_err(m_step_err), .state(state),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int bin; int wrap; int err; } exp_t;
  exp_t q[$];
  int mstate, consec, prev, merr, mwrap;
  int ncmp = 0, nfail = 0;

  function automatic int gray(int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int dec(int g);
    for (int n = 0; n < 16; n++) if (gray(n) == g) return n;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(int g);
    exp_t e;
    int d;
    if (mstate == 2) return;
    if (mstate == 0) begin
      e.bin = dec(g); e.wrap = 0; e.err = 0;
      prev = g; mstate = 1; consec = 0;
      q.push_back(e);
      return;
    end
    d = $countones(g ^ prev);
    e.bin  = dec(g);
    e.err  = (d > 1) ? 1 : 0;
    e.wrap = (d == 1 && dec(prev) == 15 && g == 0) ? 1 : 0;
    if (e.err != 0) begin
      if (merr < 255) merr++;
      consec++;
    end else consec = 0;
    mwrap = (mwrap + e.wrap) % 256;
    prev = g;
    q.push_back(e);
    if (consec == 3) mstate = 2;
  endtask

  task automatic step(bit v, int g, bit mr, bit rs);
    bit rdy, acc, pp;
    @(negedge clk);
    s_valid = v; s_gray = 4'(g); m_ready = mr; resync = rs;
    #1;
    rdy = !rs && (q.size() < 2);
    chk("s_ready", s_ready, rdy);
    chk("m_valid", m_valid, (q.size() != 0));
    if (q.size() != 0) begin
      chk("m_bin", m_bin, q[0].bin);
      chk("m_wrap", m_wrap, q[0].wrap);
      chk("m_step_err", m_step_err, q[0].err);
    end
    chk("state", state, mstate);
    chk("err_cnt", err_cnt, merr);
    chk("wrap_cnt", wrap_cnt, mwrap);
    acc = v && rdy;
    pp  = (q.size() != 0) && mr;
    if (pp) void'(q.pop_front());
    if (rs) begin mstate = 0; consec = 0; end
    else if (acc) model_word(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; resync = 1'b0;
    #1;
    q.delete(); mstate = 0; consec = 0; prev = 0; merr = 0; mwrap = 0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_state", state, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_m_bin", m_bin, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_gray = '0; m_ready = 1'b0; resync = 1'b0;
    q.delete(); mstate = 0; consec = 0; prev = 0; merr = 0; mwrap = 0;
    do_reset();

    // basic decode
    step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 3, 1, 0); step(1, 2, 1, 0);
    step(0, 0, 1, 0);
    chk("t1_state", state, 1);

    // full walk and wrap
    for (int n = 4; n < 16; n++) step(1, gray(n), 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t2_wrap_cnt", wrap_cnt, 1);
    chk("t2_err_cnt", err_cnt, 0);

    // single bad step
    step(1, 6, 1, 0);
    step(0, 0, 1, 0);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_state", state, 1);

    // reach LOST, words dropped, resync recovers
    step(1, 0, 1, 0); step(1, 6, 1, 0);
    step(1, 5, 1, 0); step(1, 7, 1, 0);
    step(0, 0, 1, 0);
    chk("t4_state_lost", state, 2);
    step(0, 0, 1, 1);
    step(1, 5, 1, 0);
    step(0, 0, 1, 0);
    chk("t4_state_track", state, 1);

    // backpressure
    for (int i = 0; i < 5; i++) step(1, gray((dec(prev) + 1) % 16), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // reset with full buffer
    step(1, 0, 0, 0);
    step(1, gray((dec(prev) + 1) % 16), 0, 0);
    step(1, 0, 0, 0);
    do_reset();

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      int k, g;
      k = $urandom_range(0, 9);
      if (k < 6)      g = gray((dec(prev) + 1) % 16);
      else if (k < 7) g = prev;
      else if (k < 8) g = 0;
      else            g = $urandom_range(0, 15);
      step($urandom_range(0, 99) < 80, g, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end
    step(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
